// File: rtl/cook_timer.sv
// Microwave countdown timer: BCD MM:SS entry, per-tick countdown while the
// magnetron runs, timerdone flag and a fixed-length expiry beep.
module cook_timer #(
   parameter int BEEP_CYCLES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       mag_on,
   input  logic       clearn,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timerdone,
   output logic       beep
);

   localparam int CW = (BEEP_CYCLES < 2) ? 1 : $clog2(BEEP_CYCLES + 1);

   typedef enum logic [1:0] {
      ENTRY,
      RUN,
      DONE
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    mt_q, mt_d;
   logic [3:0]    mo_q, mo_d;
   logic [3:0]    st_q, st_d;
   logic [3:0]    so_q, so_d;
   logic [CW-1:0] bcnt_q, bcnt_d;
   logic          done_q, done_d;
   logic          beep_q, beep_d;
   logic          zero_q;
   logic          key_ok;

   assign zero_q = ({mt_q, mo_q, st_q, so_q} == 16'd0);
   assign key_ok = key_valid && (key_digit <= 4'd9);

   always_comb begin
      state_d = state_q;
      mt_d    = mt_q;
      mo_d    = mo_q;
      st_d    = st_q;
      so_d    = so_q;
      bcnt_d  = (bcnt_q != '0) ? bcnt_q - CW'(1) : '0;

      if (!mag_on) begin
         if (!clearn) begin
            mt_d    = 4'd0;
            mo_d    = 4'd0;
            st_d    = 4'd0;
            so_d    = 4'd0;
            state_d = ENTRY;
         end else if (key_ok) begin
            // A fresh entry after expiry starts from an empty display
            if (state_q == DONE) begin
               mt_d = 4'd0;
               mo_d = 4'd0;
               st_d = 4'd0;
            end else begin
               mt_d = mo_q;
               mo_d = st_q;
               st_d = so_q;
            end
            so_d    = key_digit;
            state_d = ENTRY;
         end else if (state_q == RUN) begin
            state_d = ENTRY;
         end
      end else begin
         unique case (state_q)
            ENTRY: state_d = RUN;
            RUN: begin
               if (tick && !zero_q) begin
                  if (so_q != 4'd0) begin
                     so_d = so_q - 4'd1;
                  end else begin
                     so_d = 4'd9;
                     if (st_q != 4'd0) begin
                        st_d = st_q - 4'd1;
                     end else begin
                        st_d = 4'd5;
                        if (mo_q != 4'd0) begin
                           mo_d = mo_q - 4'd1;
                        end else begin
                           mo_d = 4'd9;
                           mt_d = mt_q - 4'd1;
                        end
                     end
                  end
                  if ({mt_d, mo_d, st_d, so_d} == 16'd0) begin
                     state_d = DONE;
                     bcnt_d  = CW'(BEEP_CYCLES);
                  end
               end
            end
            default: state_d = state_q;
         endcase
      end

      done_d = ({mt_d, mo_d, st_d, so_d} == 16'd0);
      beep_d = (bcnt_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ENTRY;
         mt_q    <= 4'd0;
         mo_q    <= 4'd0;
         st_q    <= 4'd0;
         so_q    <= 4'd0;
         bcnt_q  <= '0;
         done_q  <= 1'b1;
         beep_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mt_q    <= mt_d;
         mo_q    <= mo_d;
         st_q    <= st_d;
         so_q    <= so_d;
         bcnt_q  <= bcnt_d;
         done_q  <= done_d;
         beep_q  <= beep_d;
      end
   end

   assign min_tens  = mt_q;
   assign min_ones  = mo_q;
   assign sec_tens  = st_q;
   assign sec_ones  = so_q;
   assign timerdone = done_q;
   assign beep      = beep_q;

endmodule

// File: tb/tb_cook_timer.sv
// Scoreboard bench for cook_timer: a decimal-arithmetic model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_cook_timer;

   localparam int BEEP = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tick = 1'b0;
   logic       mag_on = 1'b0;
   logic       clearn = 1'b1;
   logic       key_valid = 1'b0;
   logic [3:0] key_digit = 4'd0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       timerdone, beep;

   cook_timer #(.BEEP_CYCLES(BEEP)) dut (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .mag_on(mag_on),
      .clearn(clearn),
      .key_valid(key_valid),
      .key_digit(key_digit),
      .min_tens(min_tens),
      .min_ones(min_ones),
      .sec_tens(sec_tens),
      .sec_ones(sec_ones),
      .timerdone(timerdone),
      .beep(beep)
   );

   always #5 clk = ~clk;

   logic [17:0] exp_q[$];
   int errors = 0;
   int checks = 0;
   int cyc = 0;

   // Reference model: the display is a 4-digit decimal number v = MM*100+SS
   int v = 0;
   int mode = 0;
   int beep_left = 0;

   function automatic logic [17:0] pack_exp(int val, int bl);
      int m, s;
      m = val / 100;
      s = val % 100;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
              (val == 0), (bl != 0)};
   endfunction

   always @(posedge clk) begin
      int m, s, nb;
      if (reset) begin
         v = 0;
         mode = 0;
         beep_left = 0;
      end else begin
         nb = (beep_left > 0) ? beep_left - 1 : 0;
         if (!mag_on) begin
            if (!clearn) begin
               v = 0;
               mode = 0;
            end else if (key_valid && key_digit <= 9) begin
               v = (mode == 2) ? int'(key_digit)
                               : (v * 10 + int'(key_digit)) % 10000;
               mode = 0;
            end else if (mode == 1) begin
               mode = 0;
            end
         end else if (mode == 0) begin
            mode = 1;
         end else if (mode == 1 && tick && v != 0) begin
            m = v / 100;
            s = v % 100;
            if (s > 0) s = s - 1;
            else begin
               s = 59;
               m = m - 1;
            end
            v = m * 100 + s;
            if (v == 0) begin
               mode = 2;
               nb = BEEP;
            end
         end
         beep_left = nb;
      end
      exp_q.push_back(pack_exp(v, beep_left));
   end

   always @(negedge clk) begin
      logic [17:0] e, a;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {min_tens, min_ones, sec_tens, sec_ones, timerdone, beep};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL outputs cycle %0d: got %h%h:%h%h done=%b beep=%b, expected %h%h:%h%h done=%b beep=%b",
                     cyc, a[17:14], a[13:10], a[9:6], a[5:2], a[1], a[0],
                     e[17:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
         end
      end
   end

   task automatic step(input logic r, input logic t, input logic m,
                       input logic c, input logic kv, input logic [3:0] kd);
      @(negedge clk);
      reset = r;
      tick = t;
      mag_on = m;
      clearn = c;
      key_valid = kv;
      key_digit = kd;
   endtask

   task automatic key(input logic [3:0] d);
      step(0, 0, 0, 1, 1, d);
      step(0, 0, 0, 1, 0, 0);
   endtask

   task automatic idle(input logic m, input int n);
      for (int i = 0; i < n; i++) step(0, 0, m, 1, 0, 0);
   endtask

   task automatic ticks(input logic m, input int n);
      for (int i = 0; i < n; i++) step(0, 1, m, 1, 0, 0);
   endtask

   initial begin
      step(1, 0, 0, 1, 0, 0);
      step(1, 0, 0, 1, 0, 0);
      idle(0, 1);
      key(1); key(3); key(0); key(15);
      key(1); key(0); key(0);
      idle(1, 1);
      ticks(1, 60);
      ticks(1, 3);
      idle(1, 4);
      step(0, 0, 0, 0, 0, 0);
      key(1); key(2);
      idle(1, 1);
      ticks(1, 5);
      ticks(0, 3);
      idle(1, 1);
      ticks(1, 7);
      idle(1, 4);
      idle(0, 1);
      key(4);
      idle(1, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1, 4);
      key(4);
      step(0, 0, 0, 0, 0, 0);
      key(9); key(9);
      idle(1, 1);
      ticks(1, 10);
      idle(0, 1);
      key(1); key(0); key(0); key(0); key(0);
      key(1);
      idle(1, 1);
      ticks(1, 1);
      step(1, 0, 1, 1, 0, 0);
      idle(0, 2);
      for (int i = 0; i < 4000; i++) begin
         logic m_r;
         m_r = ($urandom_range(0, 15) == 0) ? ~mag_on : mag_on;
         step(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 2) == 0),
              m_r,
              ($urandom_range(0, 24) != 0),
              ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)));
      end
      idle(0, 2);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() > 1) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected at most 1",
                  exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cook_timer.md
# cook_timer

Countdown timer for the microwave controller; it is the producer of `timerdone` consumed by the `Magnetron` control block and the consumer of its `mag_on`. Digits are keyed in while the magnetron is off, then counted down in MM:SS (BCD) once per `tick` while `mag_on` is high. On expiry it raises `timerdone`, which the magnetron uses to switch off, and pulses `beep` for a fixed number of cycles.

## Interface
- `BEEP_CYCLES`, default 3: number of `clk` cycles `beep` stays high on expiry; must be ≥1.
- `clk`  input  1  system clock, all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `tick`  input  1  one-cycle 1 Hz enable pulse from the prescaler.
- `mag_on`  input  1  magnetron state from the `Magnetron` block; high means cooking.
- `clearn`  input  1  clear button, active-low, synchronous level.
- `key_valid`  input  1  one-cycle strobe; `key_digit` is valid.
- `key_digit`  input  4  keyed BCD digit 0–9.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  output  4 each  registered BCD display digits.
- `timerdone`  output  1  registered; high when all four digits are 0.
- `beep`  output  1  registered expiry indicator.

## Operation
- **Reset:**
  - All digits = 0, `timerdone` = 1, `beep` = 0, beep counter = 0, state = ENTRY.
- **States:**
  - **ENTRY** (`mag_on`=0): digits are editable.
  - **RUN** (`mag_on`=1): countdown is active.
  - **DONE**: reached from RUN when the count hits 00:00.
- **Transitions:**
  - ENTRY→RUN on `mag_on`=1.
  - RUN→ENTRY on `mag_on`=0 with a nonzero count. This is a pause; digits hold.
  - RUN→DONE when a decrement produces 00:00.
  - DONE→ENTRY on `clearn`=0 or on an accepted key, once `mag_on`=0.
- **Priority per cycle:**
  1. `reset`
  2. `clearn`=0 while `mag_on`=0
  3. key entry while `mag_on`=0
  4. decrement while `mag_on`=1 and `tick`=1
- **Clear:** `clearn`=0 with `mag_on`=0 sets digits to 00:00 and state to ENTRY. It is ignored while `mag_on`=1.
- **Key entry:** accepted only when `key_valid`=1, `mag_on`=0, `key_digit`≤9.
  - Digits shift left: `min_tens`←`min_ones`, `min_ones`←`sec_tens`, `sec_tens`←`sec_ones`, `sec_ones`←`key_digit`.
  - The old `min_tens` is discarded.
  - Digits >9 are ignored with no state change.
  - A key accepted in DONE first zeroes the digits, giving 00:0d.
  - Keys while `mag_on`=1 are ignored.
- **Decrement** (RUN, `tick`=1, count ≠ 0):
  - `sec_ones`>0: `sec_ones`−1.
  - Otherwise `sec_ones`←9 and `sec_tens` borrows. If `sec_tens`>0: `sec_tens`−1.
  - Otherwise `sec_tens`←5 and minutes borrow: `min_ones`−1, or `min_ones`←9 and `min_tens`−1.
  - Seconds entered above 59 (e.g. 00:99) count down linearly through 00:90…00:60…00:59 without normalization.
- **Zero count:** `tick` with count 00:00 in RUN produces no decrement and no wrap. There is no 99:99 underflow, ever.
- **timerdone:** equals (all digits == 0) of the registered digits. The magnetron therefore cannot start on an empty timer.
- **Expiry beep:**
  - The decrement that yields 00:00 loads the beep counter with `BEEP_CYCLES`. `beep` is high while the counter is ≠0; the counter decrements every cycle.
  - `clearn`=0 does not cut the beep short. `reset` does.
- **tick outside RUN:** `tick` is ignored in ENTRY and DONE.

## Timing
- All outputs are registered. Effects are visible the cycle after the sampling edge.
- Key entry: digits update 1 cycle after the `key_valid` edge.
- Decrement: digits update 1 cycle after the `tick` edge.
- Expiry: `timerdone` and `beep` rise in the same cycle the digits become 00:00. `beep` stays high exactly `BEEP_CYCLES` cycles.
- Pause and resume: dropping `mag_on` freezes the digits from the next edge. A `tick` coincident with `mag_on`=0 is not counted.
- Simultaneous `clearn`=0 and `key_valid` with `mag_on`=0: the clear wins and the key is dropped.
- Simultaneous `tick` and `key_valid` with `mag_on`=1: the decrement applies and the key is ignored.
- `reset` mid-countdown or mid-beep: next cycle is the full reset state.

## Test plan
- **Reset:** assert `reset` 2 cycles → digits 00:00, `timerdone`=1, `beep`=0.
- **Key entry:** keys 1,3,0 then 15 → display 01:30. The 15 is ignored. `timerdone`=0.
- **Countdown:** load 01:00, `mag_on`=1, 1 tick → 00:59. Continue 59 ticks → 00:00. `timerdone`=1 on that cycle; `beep` high for exactly 3 cycles; further ticks leave 00:00.
- **Pause:**
  - Load 00:12, run 5 ticks → 00:07.
  - Drop `mag_on` and apply 3 ticks → stays 00:07.
  - Raise `mag_on` and apply 7 ticks → 00:00 with a beep.
- **Clear vs. keys:**
  - `clearn`=0 with `mag_on`=1 → digits unchanged.
  - With `mag_on`=0, `clearn`=0 and `key_valid` (digit 4) in the same cycle → 00:00.
  - A key 4 alone → 00:04.
- **Wrap and edge cases:**
  - Enter 9,9 → 00:99; 10 ticks → 00:89.
  - Enter 1,0,0,0,0 → 00:00, since the overflowed digit is discarded.
  - `reset` asserted during the beep → `beep`=0 on the next cycle.
